// File: rtl/franken_pkg.sv
// Shared definitions for the franken_riscv M-extension unit.
//   funct3 encodings, multiply/divide FSM state enum, default datapath width.
//   Imported by franken_muldiv and franken_div_step.
package franken_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/franken_div_step.sv
// One restoring-divide iteration on unsigned magnitudes (combinational).
//   Ports: rem/quo/dvs = partial remainder, dividend-shifting-into-quotient, divisor;
//          rem_next/quo_next = state after bringing down one dividend bit.
module franken_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // quo holds the not-yet-consumed dividend bits at the top and the
  // quotient bits accumulating at the bottom. Since rem < dvs, shifted
  // stays below 2*dvs, so the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[XLEN]) begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/franken_muldiv.sv
// RV32M/RV64M execute-stage multiply/divide unit with start/busy/valid handshake.
//   Ports: start/funct3/src1/src2/rd_in issue an op; flush kills it; busy holds Exec;
//          valid pulses one cycle with result/rd_out.
module franken_muldiv
  import franken_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MUL_FAST = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_t         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic              neg_main;   // negate product / quotient at the end
  logic              neg_rem;    // remainder takes the dividend's sign
  // acc is {product high, multiplier low} for multiply and {rem, quo} for divide;
  // opb is the multiplicand or the divisor magnitude.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;

  // ---------------- operand conditioning ----------------
  logic            s1_signed, s2_signed;
  logic            src1_neg, src2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, is_special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    if (!funct3[2]) begin
      s1_signed = (funct3 == M_MULH) || (funct3 == M_MULHSU);
      s2_signed = (funct3 == M_MULH);
    end else begin
      s1_signed = !funct3[0];
      s2_signed = !funct3[0];
    end
    src1_neg = s1_signed & src1[XLEN-1];
    src2_neg = s2_signed & src2[XLEN-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    mag1 = src1_neg ? (-src1) : src1;
    mag2 = src2_neg ? (-src2) : src2;

    div_zero   = (src2 == '0);
    div_ovf    = !funct3[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    is_special = funct3[2] && (div_zero || div_ovf);
    if (div_zero) special_res = funct3[1] ? src1 : '1;
    else          special_res = funct3[1] ? '0 : src1;
  end

  // ---------------- single-cycle multiply ----------------
  logic [2*XLEN-1:0] fast_prod;

  generate
    if (MUL_FAST != 0) begin : g_fast_mul
      logic [2*XLEN-1:0] a_wide, b_wide;
      // Sign extension to 2*XLEN makes the truncated product exact.
      assign a_wide    = {{XLEN{src1_neg}}, src1};
      assign b_wide    = {{XLEN{src2_neg}}, src2};
      assign fast_prod = a_wide * b_wide;
    end else begin : g_no_fast_mul
      assign fast_prod = '0;
    end
  endgenerate

  // ---------------- iterative multiply step ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_final;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    mul_final = neg_main ? (-mul_next) : mul_next;
  end

  // ---------------- divide step ----------------
  logic [XLEN-1:0] rem_next, quo_next;
  logic [XLEN-1:0] quo_fix, rem_fix;

  franken_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc[2*XLEN-1:XLEN]),
    .quo      (acc[XLEN-1:0]),
    .dvs      (opb),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    quo_fix = neg_main ? (-quo_next) : quo_next;
    rem_fix = neg_rem  ? (-rem_next) : rem_next;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op       <= M_MUL;
      rd_lat   <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      opb      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else if (flush) begin
      // result and rd_out keep their last presented values.
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        MD_IDLE, MD_DONE: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          if (start) begin
            op       <= funct3;
            rd_lat   <= rd_in;
            neg_main <= src1_neg ^ src2_neg;
            neg_rem  <= src1_neg;
            if (!funct3[2] && (MUL_FAST != 0)) begin
              state  <= MD_DONE;
              valid  <= 1'b1;
              rd_out <= rd_in;
              result <= (funct3 == M_MUL) ? fast_prod[XLEN-1:0]
                                          : fast_prod[2*XLEN-1:XLEN];
            end else if (is_special) begin
              state  <= MD_DONE;
              valid  <= 1'b1;
              rd_out <= rd_in;
              result <= special_res;
            end else begin
              state <= funct3[2] ? MD_DIV : MD_MUL;
              busy  <= 1'b1;
              cnt   <= CW'(XLEN);
              // Multiply: high half accumulates, low half is the multiplier.
              // Divide: remainder starts at 0, dividend sits in the low half.
              acc   <= funct3[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
              opb   <= funct3[2] ? mag2 : mag1;
            end
          end
        end

        MD_MUL: begin
          acc <= mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= MD_DONE;
            busy   <= 1'b0;
            valid  <= 1'b1;
            rd_out <= rd_lat;
            result <= (op == M_MUL) ? mul_final[XLEN-1:0] : mul_final[2*XLEN-1:XLEN];
          end
        end

        MD_DIV: begin
          acc <= {rem_next, quo_next};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= MD_DONE;
            busy   <= 1'b0;
            valid  <= 1'b1;
            rd_out <= rd_lat;
            result <= op[1] ? rem_fix : quo_fix;
          end
        end

        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_franken_muldiv.sv
// Directed self-checking bench for franken_muldiv.
//   Drives a MUL_FAST=1 and a MUL_FAST=0 instance from the same inputs.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_franken_muldiv;
  import franken_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic [4:0]  rd_in;

  logic        busy_f, valid_f, busy_s, valid_s;
  logic [31:0] result_f, result_s;
  logic [4:0]  rd_out_f, rd_out_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  franken_muldiv #(.XLEN(32), .MUL_FAST(1)) u_fast (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .src1(src1), .src2(src2),
    .rd_in(rd_in), .flush(flush), .busy(busy_f), .valid(valid_f), .result(result_f), .rd_out(rd_out_f)
  );

  franken_muldiv #(.XLEN(32), .MUL_FAST(0)) u_slow (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .src1(src1), .src2(src2),
    .rd_in(rd_in), .flush(flush), .busy(busy_s), .valid(valid_s), .result(result_s), .rd_out(rd_out_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one op and wait for valid on the chosen instance. lat counts cycles
  // from the start cycle to the valid cycle (0 means it never arrived).
  task automatic do_op(input bit slow, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output logic [4:0] rdo, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; funct3 = f; src1 = a; src2 = b; rd_in = rd;
    lat = 0; busy_cnt = 0; res = '0; rdo = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (slow ? busy_s : busy_f) busy_cnt++;
      if (slow ? valid_s : valid_f) begin
        lat = i;
        res = slow ? result_s : result_f;
        rdo = slow ? rd_out_s : rd_out_f;
        break;
      end
    end
  endtask

  // Let both instances drain back to idle.
  task automatic settle();
    int n;
    n = 0;
    while ((busy_f || valid_f || busy_s || valid_s) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("settle_timeout", 64'(n >= 60), 64'd0);
  endtask

  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat, bcnt, vcnt;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; src1 = '0; src2 = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy_f),   64'd0);
    check("rst_valid",  64'(valid_s),  64'd0);
    check("rst_result", 64'(result_s), 64'd0);
    check("rst_rd_out", 64'(rd_out_f), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-cycle multiply.
    do_op(1'b0, M_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd11, res, lat, rdo, bcnt);
    check("mul_fast_res", 64'(res), 64'hFFFF_FFEB);
    check("mul_fast_lat", 64'(lat), 64'd1);
    check("mul_fast_rd",  64'(rdo), 64'd11);
    settle();

    // High-half multiplies: iterative instance watched, fast instance read afterwards.
    do_op(1'b1, M_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, res, lat, rdo, bcnt);
    check("mulh_slow_res", 64'(res), 64'h4000_0000);
    check("mulh_slow_lat", 64'(lat), 64'd33);
    check("mulh_fast_res", 64'(result_f), 64'h4000_0000);
    settle();
    do_op(1'b1, M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, res, lat, rdo, bcnt);
    check("mulhu_slow_res", 64'(res), 64'hFFFF_FFFE);
    check("mulhu_slow_lat", 64'(lat), 64'd33);
    check("mulhu_fast_res", 64'(result_f), 64'hFFFF_FFFE);
    settle();
    do_op(1'b1, M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, res, lat, rdo, bcnt);
    check("mulhsu_slow_res", 64'(res), 64'hFFFF_FFFF);
    check("mulhsu_fast_res", 64'(result_f), 64'hFFFF_FFFF);
    settle();
    do_op(1'b1, M_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd4, res, lat, rdo, bcnt);
    check("mul_slow_res", 64'(res), 64'hFFFF_FFEB);
    settle();

    // Special cases resolve in one cycle.
    do_op(1'b1, M_DIV, 32'd5, 32'd0, 5'd5, res, lat, rdo, bcnt);
    check("div0_res", 64'(res), 64'hFFFF_FFFF);
    check("div0_lat", 64'(lat), 64'd1);
    settle();
    do_op(1'b1, M_REM, 32'd5, 32'd0, 5'd6, res, lat, rdo, bcnt);
    check("rem0_res", 64'(res), 64'd5);
    check("rem0_lat", 64'(lat), 64'd1);
    settle();
    do_op(1'b1, M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, res, lat, rdo, bcnt);
    check("divovf_res", 64'(res), 64'h8000_0000);
    check("divovf_lat", 64'(lat), 64'd1);
    settle();
    do_op(1'b1, M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, lat, rdo, bcnt);
    check("removf_res", 64'(res), 64'd0);
    settle();

    // Iterative divide/remainder.
    do_op(1'b1, M_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, res, lat, rdo, bcnt);
    check("div_res",  64'(res),  64'hFFFF_FFFD);
    check("div_lat",  64'(lat),  64'd33);
    check("div_busy", 64'(bcnt), 64'd32);
    check("div_rd",   64'(rdo),  64'd9);
    settle();
    do_op(1'b1, M_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, res, lat, rdo, bcnt);
    check("rem_res", 64'(res), 64'hFFFF_FFFF);
    check("rem_lat", 64'(lat), 64'd33);
    settle();
    do_op(1'b1, M_DIVU, 32'd100, 32'd7, 5'd12, res, lat, rdo, bcnt);
    check("divu_res",  64'(res),  64'd14);
    check("divu_busy", 64'(bcnt), 64'd32);
    settle();
    do_op(1'b1, M_REMU, 32'd100, 32'd7, 5'd13, res, lat, rdo, bcnt);
    check("remu_res", 64'(res), 64'd2);
    check("remu_lat", 64'(lat), 64'd33);
    settle();

    // Flush part-way through a divide.
    @(negedge clk);
    start = 1'b1; funct3 = M_DIV; src1 = 32'd100; src2 = 32'd7; rd_in = 5'd14;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",   64'(busy_s),   64'd0);
    check("flush_result", 64'(result_s), 64'd2);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_s || valid_f) vcnt++;
      @(negedge clk);
    end
    check("flush_no_valid", 64'(vcnt), 64'd0);
    do_op(1'b1, M_DIVU, 32'd9, 32'd3, 5'd15, res, lat, rdo, bcnt);
    check("post_flush_res", 64'(res), 64'd3);
    check("post_flush_lat", 64'(lat), 64'd33);
    settle();

    // Back-to-back issue in the valid cycle of a divide.
    do_op(1'b0, M_DIVU, 32'd100, 32'd7, 5'd16, res, lat, rdo, bcnt);
    check("b2b_div_res", 64'(res), 64'd14);
    start = 1'b1; funct3 = M_MUL; src1 = 32'd2; src2 = 32'd3; rd_in = 5'd17;
    @(negedge clk);
    start = 1'b0;
    check("b2b_mul_valid", 64'(valid_f),  64'd1);
    check("b2b_mul_res",   64'(result_f), 64'd6);
    check("b2b_mul_rd",    64'(rd_out_f), 64'd17);
    settle();

    // start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; funct3 = M_DIVU; src1 = 32'd100; src2 = 32'd7; rd_in = 5'd9;
    lat = 0; res = '0; rdo = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin
        funct3 = M_DIVU; src1 = 32'd50; src2 = 32'd5; rd_in = 5'd3;
      end
      if (valid_s) begin
        lat = i; res = result_s; rdo = rd_out_s;
        break;
      end
    end
    start = 1'b0;
    check("ignore_res", 64'(res), 64'd14);
    check("ignore_rd",  64'(rdo), 64'd9);
    check("ignore_lat", 64'(lat), 64'd33);
    settle();

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; funct3 = M_DIV; src1 = 32'd100; src2 = 32'd7; rd_in = 5'd20;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_result", 64'(result_s), 64'd0);
    check("mid_rst_valid",  64'(valid_s),  64'd0);
    check("mid_rst_busy",   64'(busy_s),   64'd0);
    check("mid_rst_rd",     64'(rd_out_s), 64'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_s) vcnt++;
      @(negedge clk);
    end
    check("mid_rst_no_valid", 64'(vcnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/franken_muldiv.md
Name: franken_muldiv

Overview:
- Parametrised RV32M/RV64M execute-stage unit for the franken_riscv pipeline.
- Covers all eight M-extension ops, including DIV/DIVU/REM/REMU, which the current core lacks. The current core's single-cycle MUL/MULH is replaced.
- Sits beside the ALU in Exec. The core holds its Exec stage while busy is high and captures result/rd_out when valid pulses.
- Operates in one mode: multi-cycle with a start/busy/valid handshake and a flush input.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- MUL_FAST, 1: 1 = single-cycle registered multiply; 0 = iterative shift-add multiply, XLEN cycles.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled with funct3, src1, src2 and rd_in.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  input  XLEN  rs1 operand (dividend / multiplicand), already forwarded.
- src2  input  XLEN  rs2 operand (divisor / multiplier), already forwarded.
- rd_in  input  5  destination register tag.
- flush  input  1  kills the in-flight operation (branch taken).
- busy  output  1  operation in flight and result not yet presented.
- valid  output  1  one-cycle pulse; result and rd_out are valid.
- result  output  XLEN  operation result.
- rd_out  output  5  tag captured at start.

Behaviour:
- Reset: state=IDLE; busy, valid, result and rd_out all 0; counter 0.
- Acceptance: start is accepted when state==IDLE, or in the cycle valid is high (back-to-back issue).
  - start while busy is ignored. The in-flight operation and its latched operands are untouched.
- States:
  - IDLE: accepted start goes to MUL, DIV or DONE.
    - DONE is taken directly by special cases and by MUL_FAST multiply.
  - MUL (MUL_FAST=0 only): XLEN iterations, then DONE.
  - DIV: XLEN iterations, then DONE.
  - DONE: valid=1 for exactly one cycle. Next state is IDLE, or a new op if start is accepted.
- busy = (state != IDLE) && (state != DONE).
- Latency is measured from the start cycle to the valid cycle:
  - MUL_FAST multiply: 1.
  - Iterative multiply: XLEN+1.
  - Divide/remainder: XLEN+1.
  - Special cases: 1.
  - Counter width is $clog2(XLEN)+1; it counts XLEN down to 0.
- Multiply:
  - Operands are sign-extended to XLEN+1 bits: src1 signed for MULH and MULHSU; src2 signed for MULH only.
  - The full 2*XLEN product is formed.
  - MUL returns the low XLEN bits; the other three multiply ops return the high XLEN bits.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes. For DIV/REM the magnitudes are |src1| and |src2|.
  - Sign fix-up in the DONE transition:
    - The quotient is negated if the operand signs differ.
    - The remainder takes the dividend's sign.
- Special cases (resolved at start, no iteration):
  - Divisor==0: DIV/DIVU result = all ones; REM/REMU result = src1.
  - Signed overflow (src1 = 1 followed by XLEN-1 zeros, src2 = all ones): DIV result = src1; REM result = 0.
- Flush:
  - Any state goes to IDLE on the next edge with valid=0. result holds its old value.
  - flush together with start: flush wins and the start is dropped.
  - flush during the DONE cycle does not retract the valid already being driven.
- reset mid-operation: same as flush, plus all outputs are cleared.
- rd_out and result change only when entering DONE.

Decomposition:
- Shared package franken_pkg holds:
  - funct3 constants: M_MUL … M_REMU.
  - State enum: MD_IDLE, MD_MUL, MD_DIV, MD_DONE.
  - The XLEN default.
- Sub-module franken_div_step: combinational restoring-divide iteration (remainder, quotient, divisor in; next remainder and quotient out). It is instantiated once and reused each cycle.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD (MUL_FAST=1) -> result 0xFFFFFFEB, valid exactly 1 cycle after start, rd_out = rd_in.
- High-half multiplies, run with MUL_FAST=0 and MUL_FAST=1 -> identical results; iterative valid arrives 33 cycles after start:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide, each valid at start+33 with busy high for 32 cycles:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Special cases, each valid at start+1:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Flush and reset mid-operation:
  - flush at cycle 10 of a DIV -> busy=0 next cycle, no valid pulse; a following DIVU 9/3 -> 3.
  - reset at cycle 5 -> result=0, valid=0.
- Issue rules:
  - start with MUL 2×3 in the valid cycle of a DIV -> accepted, result 6 one cycle later.
  - start while busy -> ignored; the original op's result is unchanged.
